// File: rtl/lsu_pkg.sv
// Shared widths, funct3 codes, FSM encoding and the access legality check for the LSU.
package lsu_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned F3_W_B = 3;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned HALF_W = 16;

  localparam logic [F3_W_B-1:0] F3_B  = 3'b000;
  localparam logic [F3_W_B-1:0] F3_H  = 3'b001;
  localparam logic [F3_W_B-1:0] F3_W  = 3'b010;
  localparam logic [F3_W_B-1:0] F3_BU = 3'b100;
  localparam logic [F3_W_B-1:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_e;

  // 1 when funct3 is defined for the direction and the address is naturally aligned
  function automatic logic lsu_legal(input logic we,
                                     input logic [F3_W_B-1:0] funct3,
                                     input logic [1:0] addr_lo);
    logic ok;
    ok = 1'b0;
    case (funct3)
      F3_B:    ok = 1'b1;
      F3_H:    ok = ~addr_lo[0];
      F3_W:    ok = (addr_lo == 2'b00);
      F3_BU:   ok = ~we;
      F3_HU:   ok = ~we & ~addr_lo[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane handling: load extract/extend and sub-word store merge.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [F3_W_B-1:0] funct3,
  input  logic [1:0]        addr_lo,
  input  logic [XLEN-1:0]   rd,
  input  logic [XLEN-1:0]   wdata,
  output logic [XLEN-1:0]   load_data,
  output logic [XLEN-1:0]   store_data
);

  logic [BYTE_W-1:0] byte_c;
  logic [HALF_W-1:0] half_c;

  // Pick the addressed byte and half out of the memory word
  always_comb begin
    byte_c = rd[7:0];
    case (addr_lo)
      2'd0:    byte_c = rd[7:0];
      2'd1:    byte_c = rd[15:8];
      2'd2:    byte_c = rd[23:16];
      default: byte_c = rd[31:24];
    endcase
    half_c = addr_lo[1] ? rd[31:16] : rd[15:0];
  end

  // Extend the selected lane to a full register value
  always_comb begin
    load_data = '0;
    case (funct3)
      F3_B:    load_data = {{(XLEN-BYTE_W){byte_c[BYTE_W-1]}}, byte_c};
      F3_BU:   load_data = {{(XLEN-BYTE_W){1'b0}}, byte_c};
      F3_H:    load_data = {{(XLEN-HALF_W){half_c[HALF_W-1]}}, half_c};
      F3_HU:   load_data = {{(XLEN-HALF_W){1'b0}}, half_c};
      F3_W:    load_data = rd;
      default: load_data = '0;
    endcase
  end

  // Overlay the low store bits onto the current word for SB/SH
  always_comb begin
    store_data = wdata;
    case (funct3)
      F3_B: begin
        store_data = rd;
        case (addr_lo)
          2'd0:    store_data[7:0]   = wdata[7:0];
          2'd1:    store_data[15:8]  = wdata[7:0];
          2'd2:    store_data[23:16] = wdata[7:0];
          default: store_data[31:24] = wdata[7:0];
        endcase
      end
      F3_H: begin
        store_data = rd;
        if (addr_lo[1]) store_data[31:16] = wdata[15:0];
        else            store_data[15:0]  = wdata[15:0];
      end
      default: store_data = wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit in front of a word-only memory; sub-word stores use read-modify-write.
module load_store_unit
  import lsu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [F3_W_B-1:0] req_funct3,
  input  logic [XLEN-1:0]   req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              stall,
  output logic              done,
  output logic              err,
  output logic [XLEN-1:0]   rdata,
  output logic [XLEN-1:0]   mem_A,
  output logic [XLEN-1:0]   mem_WD,
  output logic              mem_WE,
  input  logic [XLEN-1:0]   mem_RD
);

  state_e            state_q, state_d;
  logic [XLEN-1:2]   word_q;
  logic [XLEN-1:0]   wdata_q;
  logic [XLEN-1:0]   merged_q;
  logic [XLEN-1:0]   rdata_q;
  logic              err_q;
  logic              accept_c;
  logic              legal_c;
  logic [XLEN-1:0]   load_data_c;
  logic [XLEN-1:0]   store_data_c;

  assign accept_c = (state_q == IDLE) && req_valid;
  assign legal_c  = lsu_legal(req_we, req_funct3, req_addr[1:0]);

  // Lane logic only matters in the accept cycle, so it sees the live request
  lsu_align u_align (
    .funct3     (req_funct3),
    .addr_lo    (req_addr[1:0]),
    .rd         (mem_RD),
    .wdata      (req_wdata),
    .load_data  (load_data_c),
    .store_data (store_data_c)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state and memory-side decode; later states use only captured request fields
  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    done    = 1'b0;
    mem_WE  = 1'b0;
    mem_A   = {req_addr[XLEN-1:2], 2'b00};
    mem_WD  = req_wdata;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          stall = 1'b1;
          if (!legal_c || !req_we) begin
            state_d = DONE;
          end else if (req_funct3 == F3_W) begin
            mem_WE  = 1'b1;
            state_d = DONE;
          end else begin
            state_d = WRITE;
          end
        end
      end
      WRITE: begin
        stall   = 1'b1;
        mem_A   = {word_q, 2'b00};
        mem_WD  = merged_q;
        mem_WE  = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        mem_A   = {word_q, 2'b00};
        mem_WD  = wdata_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Capture the request, merged store word, error flag and load result at accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q   <= '0;
      wdata_q  <= '0;
      merged_q <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else if (accept_c) begin
      word_q   <= req_addr[XLEN-1:2];
      wdata_q  <= req_wdata;
      merged_q <= store_data_c;
      err_q    <= ~legal_c;
      if (!legal_c)     rdata_q <= '0;
      else if (!req_we) rdata_q <= load_data_c;
    end
  end

  assign err   = err_q;
  assign rdata = rdata_q;

endmodule
